freq_meter: RTL and testbench
=============================

# freq_meter

Measures the frequency and period of an external digital signal against the system clock, for example a fan tachometer or a frequency-output temperature sensor. It complements the clock divider chain, which turns the fast clock into slow ones; this block takes a slow, asynchronous signal and converts it into numbers. It runs back-to-back gate windows and reports the count of rising edges per window. It also reports the clock-cycle count between consecutive rising edges, for reciprocal measurement at low frequency.

## Interface
- `GATE_CYCLES`, default 24000000: gate window length in `clk` cycles (1 s at 24 MHz). Must be ≥ 2.
- `CNT_W`, default 24: width of the edge count.
- `PER_W`, default 32: width of the period count.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  measurement enable.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `freq`  out  CNT_W  rising edges counted in the last completed window.
- `freq_valid`  out  1  one-cycle pulse when `freq` updates.
- `freq_sat`  out  1  the last window's edge count saturated.
- `no_signal`  out  1  the last completed window had zero edges.
- `period`  out  PER_W  `clk` cycles between the last two rising edges.
- `period_valid`  out  1  one-cycle pulse when `period` updates.

## Operation
- **Input path:** `sig_in` passes through a 2-flop synchronizer and then a registered rising-edge detector. This produces `edge`, a one-cycle internal pulse.
- **FSM states:**
  - IDLE: counters cleared; no valid pulses. Go to GATE when `en`=1.
  - GATE: `gate_cnt` runs from 0 to GATE_CYCLES−1.
    - On the cycle where `gate_cnt` = GATE_CYCLES−1, latch the edge count into `freq`, including an `edge` occurring on that same cycle. Clear the edge counter and return `gate_cnt` to 0; there is no dead cycle between windows.
    - `en`=0 in any state forces IDLE on the next cycle. The partial window is discarded and no `freq_valid` is issued.
- **Edge counter:** saturates at 2^CNT_W−1 and sets a window-saturated flag. `freq_sat` is updated together with `freq`.
- **no_signal:** set when a completed window latches `freq`=0; cleared when a completed window latches a nonzero value.
- **Period path** (active while the FSM is not in IDLE):
  - `per_cnt` increments every cycle and saturates at 2^PER_W−1.
  - The first `edge` after entering GATE only arms the path: `per_cnt` is set to 1 and nothing is output.
  - Each later `edge`:
    - If `per_cnt` is not saturated: `period` ← `per_cnt` and `period_valid` pulses.
    - If `per_cnt` is saturated: the measurement is dropped with no pulse.
    - In both cases `per_cnt` restarts at 1.
- **Entering IDLE** disarms the period path. `freq`, `period`, `freq_sat` and `no_signal` hold their last values.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE, and the synchronizer flops are 0. Reset takes effect immediately and asynchronously, including mid-window.
- **Input latency:** `sig_in` first sampled high at clock edge k produces `edge` asserted during cycle k+2.
- **Input limits:** `sig_in` high and low phases must each be ≥ 2 `clk` cycles, giving a maximum measurable frequency of `clk`/4.
- **First window:** `en` rising, sampled at edge e, means GATE starts at e+1. The first `freq_valid` pulse is at e+1+GATE_CYCLES, one cycle after the latch cycle, and every GATE_CYCLES cycles after that.
- **Period output latency:** `period_valid` is asserted in the cycle after the cycle in which `edge` is high.
- `freq` and `freq_valid` change in the same cycle; likewise `period` and `period_valid`.

## Structure
- **`freq_meter_pkg`:** FSM state enum (IDLE, GATE) and default parameter constants.
- **Sub-module `edge_sync`:** 2-flop synchronizer plus rising-edge detector, with ports `clk`, `rst_n`, `d`, `rise`. It is reusable for other asynchronous inputs.

## Test plan
- **Basic count and period:** GATE_CYCLES=100, `sig_in` period 10 (5 high/5 low), `en`=1 → `freq`=10 on each `freq_valid` (one pulse every 100 cycles), `period`=10 on each `period_valid`, `no_signal`=0.
- **No signal, then recovery:** `sig_in` held at 0 for 3 windows → `freq`=0 and `no_signal`=1 after the first window. Then toggle with period 20 → after the next complete window, `freq`=5 and `no_signal`=0.
- **Edge-count saturation:** CNT_W=4, GATE_CYCLES=100, `sig_in` period 4 → 25 edges, so `freq`=15 and `freq_sat`=1. Then period 10 → `freq`=10 and `freq_sat`=0.
- **Disable mid-window:** drop `en` at window cycle 50 → no `freq_valid`, outputs hold last values. Re-enable → the next `freq_valid` arrives exactly GATE_CYCLES+1 cycles after `en` is sampled high.
- **Reset mid-window:** assert `rst_n`=0 mid-window → all outputs are 0 before the next clock edge. After release, the FSM stays in IDLE until `en` is sampled high.
- **Period saturation:** PER_W=6, `sig_in` period 80 → no `period_valid` after arming. Then period 20 → `period`=20 from the second edge onward.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default parameter values for the frequency/period meter.
package freq_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   localparam int DEF_GATE_CYCLES = 24000000;
   localparam int DEF_CNT_W       = 24;
   localparam int DEF_PER_W       = 32;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous input.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1   <= d;
         sync2   <= sync1;
         sync2_q <= sync2;
      end
   end

   // One-cycle pulse on the synchronized 0->1 transition.
   assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter (frequency) plus edge-to-edge cycle counter (period) for a slow async signal.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int PER_W       = DEF_PER_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             freq_sat,
   output logic             no_signal,
   output logic [PER_W-1:0] period,
   output logic             period_valid
);

   localparam int               GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [PER_W-1:0] PER_MAX   = '1;

   state_t           state;
   state_t           state_nxt;
   logic             gate_active;
   logic             gate_end;
   logic             sig_rise;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             win_sat;
   logic [CNT_W-1:0] cnt_final;
   logic             sat_final;
   logic [PER_W-1:0] per_cnt;
   logic             armed;

   edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig_in),
      .rise  (sig_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)  state_nxt = GATE;
         GATE:    if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Dropping en while in GATE discards the window immediately, including a would-be latch cycle.
   always_comb begin
      gate_active = (state == GATE) && en;
      gate_end    = gate_active && (gate_cnt == GATE_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        gate_cnt <= '0;
      else if (!gate_active || gate_end) gate_cnt <= '0;
      else                               gate_cnt <= gate_cnt + 1'b1;
   end

   // Count as it would stand after this cycle, so an edge on the latch cycle is included.
   assign cnt_final = (sig_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
   assign sat_final = win_sat | (sig_rise & (edge_cnt == CNT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         win_sat  <= 1'b0;
      end else if (!gate_active || gate_end) begin
         edge_cnt <= '0;
         win_sat  <= 1'b0;
      end else begin
         edge_cnt <= cnt_final;
         win_sat  <= sat_final;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq       <= '0;
         freq_valid <= 1'b0;
         freq_sat   <= 1'b0;
         no_signal  <= 1'b0;
      end else begin
         freq_valid <= gate_end;
         if (gate_end) begin
            freq      <= cnt_final;
            freq_sat  <= sat_final;
            no_signal <= (cnt_final == '0);
         end
      end
   end

   // First edge only arms; a saturated interval is dropped but still restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt      <= '0;
         armed        <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!gate_active) begin
            per_cnt <= '0;
            armed   <= 1'b0;
         end else if (sig_rise) begin
            per_cnt <= PER_W'(1);
            armed   <= 1'b1;
            if (armed && (per_cnt != PER_MAX)) begin
               period       <= per_cnt;
               period_valid <= 1'b1;
            end
         end else if (per_cnt != PER_MAX) begin
            per_cnt <= per_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter with a timestamp-based reference model.
module tb_freq_meter;

   localparam int G     = 100;
   localparam int CNT_W = 4;
   localparam int PER_W = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int PMAX  = (1 << PER_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] freq;
   logic             freq_valid;
   logic             freq_sat;
   logic             no_signal;
   logic [PER_W-1:0] period;
   logic             period_valid;

   freq_meter #(
      .GATE_CYCLES (G),
      .CNT_W       (CNT_W),
      .PER_W       (PER_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sig_in       (sig_in),
      .freq         (freq),
      .freq_valid   (freq_valid),
      .freq_sat     (freq_sat),
      .no_signal    (no_signal),
      .period       (period),
      .period_valid (period_valid)
   );

   typedef struct {
      int t;
      int f;
      bit sat;
      bit ns;
   } freq_exp_t;

   typedef struct {
      int t;
      int p;
   } per_exp_t;

   freq_exp_t fq[$];
   per_exp_t  pq[$];
   int        pend[$];

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   bit running = 0;
   bit armed = 0;
   bit prev_sig = 0;
   int win_start = 0;
   int count = 0;
   int last_edge = 0;
   int last_freq = 0;
   bit last_sat = 0;
   bit last_ns = 0;
   int last_period = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: rising edges become visible two clocks after first being sampled high;
   // windows are G clocks long starting the clock after en is first seen high.
   task automatic modelStep();
      bit edge_now;
      freq_exp_t fe;
      per_exp_t  pe;
      cyc++;
      if (!rst_n) begin
         running = 0; prev_sig = 0;
         pend.delete(); fq.delete(); pq.delete();
         last_freq = 0; last_sat = 0; last_ns = 0; last_period = 0;
         return;
      end
      edge_now = 0;
      while (pend.size() > 0 && pend[0] <= cyc) begin
         if (pend[0] == cyc) edge_now = 1;
         void'(pend.pop_front());
      end
      if (sig_in && !prev_sig) pend.push_back(cyc + 2);
      prev_sig = sig_in;
      if (!running) begin
         if (en) begin
            running = 1; win_start = cyc; count = 0; armed = 0;
         end
      end else if (!en) begin
         running = 0;
      end else begin
         if (edge_now) begin
            count++;
            if (armed && (cyc - last_edge) < PMAX) begin
               pe.t = cyc; pe.p = cyc - last_edge;
               pq.push_back(pe);
               last_period = pe.p;
            end
            armed = 1;
            last_edge = cyc;
         end
         if ((cyc - win_start) % G == 0) begin
            fe.t = cyc;
            fe.f = (count > CMAX) ? CMAX : count;
            fe.sat = (count > CMAX);
            fe.ns = (count == 0);
            fq.push_back(fe);
            last_freq = fe.f; last_sat = fe.sat; last_ns = fe.ns;
            count = 0;
         end
      end
   endtask

   task automatic applyStimulus(input bit en_v, input bit sig_v);
      @(posedge clk);
      modelStep();
      @(negedge clk);
      en = en_v;
      sig_in = sig_v;
   endtask

   task automatic runWave(input int hi, input int lo, input int n, input bit en_v);
      for (int i = 0; i < n; i++) applyStimulus(en_v, (i % (hi + lo)) < hi);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_freq"}, freq, 0);
      checkOutput({tag, "_freq_valid"}, freq_valid, 0);
      checkOutput({tag, "_freq_sat"}, freq_sat, 0);
      checkOutput({tag, "_no_signal"}, no_signal, 0);
      checkOutput({tag, "_period"}, period, 0);
      checkOutput({tag, "_period_valid"}, period_valid, 0);
   endtask

   task automatic monitor();
      freq_exp_t fe;
      per_exp_t  pe;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (freq_valid) begin
               if (fq.size() == 0) checkOutput("freq_valid_unexpected", 1, 0);
               else begin
                  fe = fq.pop_front();
                  checkOutput("freq_valid_time", cyc, fe.t);
                  checkOutput("freq", freq, fe.f);
                  checkOutput("freq_sat", freq_sat, fe.sat);
                  checkOutput("no_signal", no_signal, fe.ns);
               end
            end
            if (fq.size() > 0 && fq[0].t < cyc) begin
               checkOutput("freq_valid_missing", cyc, fq[0].t);
               void'(fq.pop_front());
            end
            if (period_valid) begin
               if (pq.size() == 0) checkOutput("period_valid_unexpected", 1, 0);
               else begin
                  pe = pq.pop_front();
                  checkOutput("period_valid_time", cyc, pe.t);
                  checkOutput("period", period, pe.p);
               end
            end
            if (pq.size() > 0 && pq[0].t < cyc) begin
               checkOutput("period_valid_missing", cyc, pq[0].t);
               void'(pq.pop_front());
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      sig_in = 1'b0;
      fork
         monitor();
      join_none
      for (int i = 0; i < 3; i++) applyStimulus(0, 0);
      checkAllZero("reset");
      rst_n = 1'b1;
      runWave(0, 1, 5, 0);

      // Directed scenarios: basic, no signal and recovery, saturation, recovery from it.
      runWave(5, 5, 350, 1);
      runWave(0, 1, 300, 1);
      runWave(10, 10, 250, 1);
      runWave(2, 2, 250, 1);
      runWave(5, 5, 200, 1);

      // Disable at window cycle 50; outputs must hold.
      for (int i = 0; i < G && ((cyc - win_start) % G) != 50; i++) applyStimulus(1, 0);
      runWave(5, 5, 30, 0);
      checkOutput("hold_freq", freq, last_freq);
      checkOutput("hold_freq_sat", freq_sat, last_sat);
      checkOutput("hold_no_signal", no_signal, last_ns);
      checkOutput("hold_period", period, last_period);
      runWave(5, 5, 250, 1);

      // Period saturation then recovery.
      runWave(40, 40, 400, 1);
      runWave(10, 10, 200, 1);

      for (int s = 0; s < 80; s++) begin
         int hi;
         int lo;
         int n;
         bit ev;
         hi = $urandom_range(2, 40);
         lo = $urandom_range(2, 40);
         n  = $urandom_range(20, 120);
         ev = ($urandom_range(0, 9) != 0);
         runWave(hi, lo, n, ev);
      end

      // Asynchronous reset partway through a window.
      runWave(6, 6, 150, 1);
      #2 rst_n = 1'b0;
      #1 checkAllZero("midreset");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0);
      rst_n = 1'b1;
      runWave(3, 3, 40, 0);
      checkOutput("idle_after_reset_freq", freq, 0);
      checkOutput("idle_after_reset_period", period, 0);
      runWave(6, 6, 350, 1);
      runWave(0, 1, 5, 0);

      checkOutput("freq_queue_drained", fq.size(), 0);
      checkOutput("period_queue_drained", pq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
